wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 95 +++++++++
 rtl/wb_ctrl.sv | 155 +++++++++++++++
 tb/tb_wb_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback controller.
//   WB_DEPTH_DEFAULT : default number of queued writeback entries
//   wb_entry_t       : one queued register-file write {dest, data}
//   wb_state_t       : writeback FSM states
package wb_pkg;

    localparam int WB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular queue of pending register-file writes.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_entry    : append an entry at the tail
//   pop                 : drop the head entry (its write has been acknowledged)
//   flush_all           : discard every entry (controller idle)
//   flush_keep          : discard all but the head (head write is in flight)
//   head_entry          : entry at the head
//   count, full         : occupancy 0..DEPTH and full flag
//   slots, slot_vld     : raw storage and per-slot valid bits, present only
//                         when WB_SCOREBOARD_EN is defined
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       flush_all,
    input  logic                       flush_keep,
    output wb_entry_t                  head_entry,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
`ifdef WB_SCOREBOARD_EN
    ,
    output wb_entry_t [DEPTH-1:0]      slots,
    output logic [DEPTH-1:0]           slot_vld
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]          head_ptr;
    logic [PW-1:0]          tail_ptr;
    logic [PW-1:0]          head_inc;
    wb_entry_t [DEPTH-1:0]  mem;

    assign head_inc   = head_ptr + 1'b1;
    assign head_entry = mem[head_ptr];
    assign full       = (count == CW'(DEPTH));

    // Storage needs no reset: only slots covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush_all) begin
            tail_ptr <= head_ptr;
            count    <= '0;
        end else if (flush_keep) begin
            // Only the head survives; if it retires this same edge the queue
            // ends up empty with tail == new head.
            head_ptr <= pop ? head_inc : head_ptr;
            tail_ptr <= head_inc;
            count    <= pop ? '0 : CW'(1);
        end else begin
            if (pop) begin
                head_ptr <= head_inc;
            end
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [PW-1:0] offset;

    assign slots = mem;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        slot_vld = '0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PW'(i) - head_ptr;
            slot_vld[i] = ({1'b0, offset} < count);
        end
    end
`endif

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: writeback controller. Arbitrates ALU and load results into a
// queue and drains it to the register file one write at a time.
// Handshake: a producer's result is taken on an edge where its *_vld and
// *_rdy are both high; rdy never depends on a same-cycle pop, and the mem
// port always wins over the alu port.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   alu_vld/alu_dest/alu_data/alu_rdy : ALU result port
//   mem_vld/mem_dest/mem_data/mem_rdy : load result port (higher priority)
//   flush                          : drop queued writes not yet issued
//   wr/dest_out/data_out           : register-file write strobe and payload
//   wr_success                     : register-file ack, cycle after wr
//   busy                           : per-GPR pending-write mask
//   empty                          : nothing queued and FSM idle
//   fsm_state                      : current FSM state (debug)
// Optional feature: define WB_SCOREBOARD_EN to build the busy mask;
// otherwise busy is tied to zero.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_vld,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    output logic        alu_rdy,
    input  logic        mem_vld,
    input  logic [2:0]  mem_dest,
    input  logic [15:0] mem_data,
    output logic        mem_rdy,
    input  logic        flush,
    output logic        wr,
    output logic [2:0]  dest_out,
    output logic [15:0] data_out,
    input  logic        wr_success,
    output logic [7:0]  busy,
    output logic        empty,
    output wb_state_t   fsm_state
);

    localparam int CW = $clog2(WB_DEPTH) + 1;

    wb_state_t      state;
    wb_state_t      state_nx;
    logic           push;
    logic           pop;
    logic           flush_all;
    logic           flush_keep;
    wb_entry_t      push_entry;
    wb_entry_t      head_entry;
    logic [CW-1:0]  count;
    logic           full;

`ifdef WB_SCOREBOARD_EN
    wb_entry_t [WB_DEPTH-1:0] slots;
    logic [WB_DEPTH-1:0]      slot_vld;
`endif

    wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush_all  (flush_all),
        .flush_keep (flush_keep),
        .head_entry (head_entry),
        .count      (count),
        .full       (full)
`ifdef WB_SCOREBOARD_EN
        ,
        .slots      (slots),
        .slot_vld   (slot_vld)
`endif
    );

    assign mem_rdy = !full && !flush;
    assign alu_rdy = !full && !flush && !mem_vld;
    assign push    = (mem_vld && mem_rdy) || (alu_vld && alu_rdy);

    always_comb begin
        push_entry = '0;
        if (mem_vld) begin
            push_entry.dest = mem_dest;
            push_entry.data = mem_data;
        end else begin
            push_entry.dest = alu_dest;
            push_entry.data = alu_data;
        end
    end

    // Once a write is issued the head must stay to finish, so flush only
    // clears everything while idle.
    assign flush_all  = flush && (state == IDLE);
    assign flush_keep = flush && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                // A flush here empties the queue, so there is nothing to issue.
                if ((count != '0) && !flush) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                state_nx = ACK;
            end
            ACK: begin
                if (wr_success) begin
                    pop = 1'b1;
                    // Entries remain after this pop when more than the head
                    // is queued or one arrives now; a flush leaves none.
                    state_nx = (!flush && ((count > CW'(1)) || push)) ? WRITE : IDLE;
                end else begin
                    state_nx = WRITE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign wr        = (state == WRITE);
    assign dest_out  = wr ? head_entry.dest : 3'd0;
    assign data_out  = wr ? head_entry.data : 16'd0;
    assign empty     = (count == '0) && (state == IDLE);
    assign fsm_state = state;

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        busy = 8'h00;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (slot_vld[i]) begin
                busy[slots[i].dest] = 1'b1;
            end
        end
    end
`else
    assign busy = 8'h00;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: self-checking bench for wb_ctrl (WB_DEPTH = 4). A queue-based
// model predicts every output each cycle; directed scenarios add literal
// expectations; a randomized phase follows.
module tb_wb_ctrl;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
    localparam logic [7:0] BUSY_MASK = 8'hFF;
`else
    localparam logic [7:0] BUSY_MASK = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_vld = 1'b0;
    logic [2:0]  alu_dest = '0;
    logic [15:0] alu_data = '0;
    logic        alu_rdy;
    logic        mem_vld = 1'b0;
    logic [2:0]  mem_dest = '0;
    logic [15:0] mem_data = '0;
    logic        mem_rdy;
    logic        flush = 1'b0;
    logic        wr;
    logic [2:0]  dest_out;
    logic [15:0] data_out;
    logic        wr_success = 1'b0;
    logic [7:0]  busy;
    logic        empty;
    wb_state_t   fsm_state;

    wb_ctrl #(.WB_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_vld    (alu_vld),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .alu_rdy    (alu_rdy),
        .mem_vld    (mem_vld),
        .mem_dest   (mem_dest),
        .mem_data   (mem_data),
        .mem_rdy    (mem_rdy),
        .flush      (flush),
        .wr         (wr),
        .dest_out   (dest_out),
        .data_out   (data_out),
        .wr_success (wr_success),
        .busy       (busy),
        .empty      (empty),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending writes in push order, plus where the head write is
    // (0 = nothing issued, 1 = strobe cycle, 2 = waiting for ack).
    logic [18:0] mq[$];
    int          m_phase = 0;
    bit          model_ok = 0;

    logic [18:0] wr_log[$];    // every cycle the DUT strobes wr
    logic [18:0] done_log[$];  // DUT writes that were acknowledged
    logic        last_wr = 1'b0;
    logic [18:0] last_entry = '0;
    logic        last_alu_rdy = 1'b0;
    logic        last_mem_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic compare_outputs();
        bit          exp_full;
        bit          exp_wr;
        logic [18:0] e;
        logic [7:0]  b;
        exp_full = (mq.size() == DEPTH);
        exp_wr   = (m_phase == 1);
        e = '0;
        if (exp_wr && mq.size() > 0) e = mq[0];
        b = '0;
        foreach (mq[k]) b[mq[k][18:16]] = 1'b1;
        chk("mem_rdy", mem_rdy, !exp_full && !flush);
        chk("alu_rdy", alu_rdy, !exp_full && !flush && !mem_vld);
        chk("wr", wr, exp_wr);
        chk("dest_out", dest_out, e[18:16]);
        chk("data_out", data_out, e[15:0]);
        chk("busy", busy, b & BUSY_MASK);
        chk("empty", empty, (mq.size() == 0) && (m_phase == 0));
    endtask

    task automatic model_update(input logic r, input logic mv, input logic [2:0] md,
                                input logic [15:0] mdat, input logic av, input logic [2:0] ad,
                                input logic [15:0] adat, input logic fl, input logic ws);
        bit          full_now;
        bit          mrdy;
        bit          ardy;
        bit          popped;
        bit          had_entries;
        logic [18:0] tmp;
        if (r) begin
            mq.delete();
            m_phase  = 0;
            model_ok = 1;
            return;
        end
        full_now    = (mq.size() == DEPTH);
        mrdy        = !full_now && !fl;
        ardy        = mrdy && !mv;
        popped      = (m_phase == 2) && ws;
        had_entries = (mq.size() > 0);
        if (popped) tmp = mq.pop_front();
        if (fl) begin
            if (m_phase != 0 && !popped) begin
                while (mq.size() > 1) tmp = mq.pop_back();
            end else begin
                mq.delete();
            end
        end
        if (mv && mrdy) mq.push_back({md, mdat});
        else if (av && ardy) mq.push_back({ad, adat});
        case (m_phase)
            0: if (had_entries && !fl) m_phase = 1;
            1: m_phase = 2;
            default: m_phase = ws ? ((mq.size() > 0) ? 1 : 0) : 1;
        endcase
    endtask

    // One clock cycle: drive inputs after the falling edge, check just
    // after, advance the model, then observe state just after the rise.
    task automatic step(input logic r, input logic mv, input logic [2:0] md,
                        input logic [15:0] mdat, input logic av, input logic [2:0] ad,
                        input logic [15:0] adat, input logic fl, input logic ws);
        @(negedge clk);
        rst = r; mem_vld = mv; mem_dest = md; mem_data = mdat;
        alu_vld = av; alu_dest = ad; alu_data = adat; flush = fl; wr_success = ws;
        #1;
        last_alu_rdy = alu_rdy;
        last_mem_rdy = mem_rdy;
        if (last_wr && ws) done_log.push_back(last_entry);
        last_wr    = (wr === 1'b1) && !r;
        last_entry = {dest_out, data_out};
        if (model_ok) compare_outputs();
        model_update(r, mv, md, mdat, av, ad, adat, fl, ws);
        @(posedge clk);
        #1;
        if (wr === 1'b1) wr_log.push_back({dest_out, data_out});
    endtask

    task automatic idle(input int n, input logic ws);
        repeat (n) step(0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 0, ws);
    endtask

    task automatic do_reset();
        step(1, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 0, 0);
        wr_log.delete();
        done_log.delete();
        last_wr = 1'b0;
    endtask

    task automatic push_mem(input logic [2:0] d, input logic [15:0] v, input logic ws);
        for (int a = 0; a < 50; a++) begin
            step(0, 1, d, v, 0, 3'd0, 16'd0, 0, ws);
            if (last_mem_rdy) return;
        end
        fail_now("push_mem_timeout");
    endtask

    initial begin
        // ---- reset values ----
        do_reset();
        chk("rst_wr", wr, 0);
        chk("rst_dest", dest_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_mem_rdy", mem_rdy, 1);
        chk("rst_alu_rdy", alu_rdy, 1);

        // ---- single write ----
        push_mem(3'd3, 16'hBEEF, 0);
        chk("single_wr_e0", wr, 0);
        idle(1, 0);
        chk("single_wr_e1", wr, 1);
        chk("single_dest", dest_out, 3);
        chk("single_data", data_out, 16'hBEEF);
        idle(1, 1);
        chk("single_wr_e2", wr, 0);
        idle(1, 1);
        chk("single_empty", empty, 1);
        chk("single_done", done_log.size(), 1);

        // ---- arbitration ----
        do_reset();
        step(0, 1, 3'd2, 16'h0022, 1, 3'd1, 16'h0011, 0, 1);
        chk("arb_mem_rdy", last_mem_rdy, 1);
        chk("arb_alu_rdy", last_alu_rdy, 0);
        step(0, 0, 3'd0, 16'd0, 1, 3'd1, 16'h0011, 0, 1);
        chk("arb_alu_rdy2", last_alu_rdy, 1);
        idle(8, 1);
        chk("arb_count", done_log.size(), 2);
        if (done_log.size() == 2) begin
            chk("arb_first", done_log[0], {3'd2, 16'h0022});
            chk("arb_second", done_log[1], {3'd1, 16'h0011});
        end

        // ---- full and wrap-around ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bit acc;
            acc = 0;
            for (int a = 0; a < 50 && !acc; a++) begin
                step(0, 1, 3'(i), 16'hA000 + 16'(i), 0, 3'd0, 16'd0, 0, i >= 4);
                if (i == 4 && a == 0) chk("full_mem_rdy", last_mem_rdy, 0);
                acc = last_mem_rdy;
            end
            if (!acc) fail_now("full_push_timeout");
        end
        idle(30, 1);
        chk("wrap_count", done_log.size(), 6);
        if (done_log.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("wrap_order", done_log[k], {3'(k), 16'hA000 + 16'(k)});
        end
        chk("wrap_empty", empty, 1);

        // ---- retry ----
        do_reset();
        push_mem(3'd6, 16'h1234, 0);
        idle(1, 0);
        chk("retry_wr1", wr, 1);
        idle(1, 0);
        chk("retry_ack", wr, 0);
        idle(1, 0);
        chk("retry_wr2", wr, 1);
        chk("retry_dest", dest_out, 6);
        chk("retry_data", data_out, 16'h1234);
        chk("retry_busy", busy, 8'h40 & BUSY_MASK);
        idle(1, 1);
        chk("retry_not_empty", empty, 0);
        idle(1, 1);
        chk("retry_empty", empty, 1);
        chk("retry_done", done_log.size(), 1);

        // ---- flush while writing ----
        do_reset();
        push_mem(3'd1, 16'h000A, 0);
        push_mem(3'd2, 16'h000B, 0);
        push_mem(3'd3, 16'h000C, 0);
        idle(1, 0);
        chk("flush_in_write", wr, 1);
        step(0, 0, 3'd0, 16'd0, 0, 3'd0, 16'd0, 1, 0);
        idle(6, 1);
        chk("flush_done", done_log.size(), 1);
        if (done_log.size() == 1) chk("flush_head", done_log[0], {3'd1, 16'h000A});
        begin
            int others;
            others = 0;
            foreach (wr_log[k]) if (wr_log[k][18:16] != 3'd1) others++;
            chk("flush_dropped", others, 0);
        end
        chk("flush_empty", empty, 1);

        // ---- scoreboard ----
        do_reset();
        push_mem(3'd5, 16'h5551, 1);
        chk("sb_busy_e0", busy, 8'h20 & BUSY_MASK);
        push_mem(3'd5, 16'h5552, 1);
        idle(2, 1);
        chk("sb_busy_first_pop", busy, 8'h20 & BUSY_MASK);
        idle(1, 1);
        chk("sb_busy_ack2", busy, 8'h20 & BUSY_MASK);
        idle(1, 1);
        chk("sb_busy_clear", busy, 0);
        chk("sb_empty", empty, 1);

        // ---- randomized traffic ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
        end
        idle(12, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
